// File: rtl/wb_timeout_bridge.sv
// -----------------------------------------------------------------------------
// wb_timeout_bridge
//   Registered Wishbone slice sitting between the Caravel Wishbone master and
//   the multi-project harness. Every request outside the two local status
//   words is forwarded downstream. If the harness never acks, the bridge
//   answers the master itself with TIMEOUT_DATA after TIMEOUT_CYCLES cycles.
//   Timeouts are counted in a saturating counter, and the address of the most
//   recent timeout is kept.
//
//   Local status words
//     STATUS_ADDR   R: zero-extended timeout count
//                   W: clears the count when wbs_sel_i[0] is set
//     STATUS_ADDR+4 R: address of the last timed-out request
//                   W: ignored, but still acked
//
// Ports
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i    upstream cycle, strobe and write enable
//   wbs_sel_i, wbs_adr_i    upstream byte select and address
//   wbs_dat_i               upstream write data
//   wbs_ack_o, wbs_dat_o    upstream one-cycle ack, and read data valid with it
//   h_cyc_o/h_stb_o         downstream cycle/strobe, always driven together
//   h_we_o/h_sel_o          downstream we/sel, registered copies of the request
//   h_adr_o/h_dat_o         downstream address/data, registered copies
//   h_ack_i, h_dat_i        downstream ack and read data
//   timeout_irq             one-cycle pulse per timeout
// -----------------------------------------------------------------------------
module wb_timeout_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF,
   parameter logic [31:0] STATUS_ADDR    = 32'h30000FF0,
   parameter int unsigned CNT_WIDTH      = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        h_cyc_o,
   output logic        h_stb_o,
   output logic        h_we_o,
   output logic [3:0]  h_sel_o,
   output logic [31:0] h_adr_o,
   output logic [31:0] h_dat_o,
   input  logic        h_ack_i,
   input  logic [31:0] h_dat_i,
   output logic        timeout_irq
);

   localparam int unsigned       WAIT_W       = $clog2(TIMEOUT_CYCLES);
   localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]       STATUS_ADDR4 = STATUS_ADDR + 32'd4;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_LOCAL, S_RESP, S_DRAIN
   } state_e;

   state_e                 state_q, state_d;
   logic [WAIT_W-1:0]      wait_q, wait_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [31:0]            last_q, last_d;
   logic [31:0]            dat_q, dat_d;
   logic                   irq_q, irq_d;
   logic                   h_we_q, h_we_d;
   logic [3:0]             h_sel_q, h_sel_d;
   logic [31:0]            h_adr_q, h_adr_d;
   logic [31:0]            h_dat_q, h_dat_d;
   // latched decode of a local access: which word, read/write, byte lane 0
   logic                   loc_hi_q, loc_hi_d;
   logic                   loc_we_q, loc_we_d;
   logic                   loc_sel0_q, loc_sel0_d;

   logic req, hit_lo, hit_hi, wait_last, drain_done;

   assign req        = wbs_cyc_i & wbs_stb_i;
   assign hit_lo     = (wbs_adr_i == STATUS_ADDR);
   assign hit_hi     = (wbs_adr_i == STATUS_ADDR4);
   assign wait_last  = (wait_q == WAIT_LAST);
   // a held strobe keeps us in DRAIN so it is never taken as a new request
   assign drain_done = ~wbs_stb_i | ~wbs_cyc_i;

   // ---------------- state register ----------------
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req) state_d = (hit_lo | hit_hi) ? S_LOCAL : S_REQ;
         // abort beats ack: the master has left the cycle and must not be acked
         S_REQ: begin
            if (!wbs_cyc_i)                state_d = S_IDLE;
            else if (h_ack_i || wait_last) state_d = S_RESP;
         end
         S_LOCAL: state_d = S_RESP;
         S_RESP:  state_d = S_DRAIN;
         S_DRAIN: if (drain_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- outputs decoded from state ----------------
   always_comb begin
      h_cyc_o   = (state_q == S_REQ);
      h_stb_o   = (state_q == S_REQ);
      wbs_ack_o = (state_q == S_RESP);
   end

   assign wbs_dat_o   = dat_q;
   assign timeout_irq = irq_q;
   assign h_we_o      = h_we_q;
   assign h_sel_o     = h_sel_q;
   assign h_adr_o     = h_adr_q;
   assign h_dat_o     = h_dat_q;

   // ---------------- datapath next values ----------------
   always_comb begin
      wait_d     = wait_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      dat_d      = dat_q;
      irq_d      = 1'b0;
      h_we_d     = h_we_q;
      h_sel_d    = h_sel_q;
      h_adr_d    = h_adr_q;
      h_dat_d    = h_dat_q;
      loc_hi_d   = loc_hi_q;
      loc_we_d   = loc_we_q;
      loc_sel0_d = loc_sel0_q;
      case (state_q)
         S_IDLE: begin
            wait_d = '0;
            if (req) begin
               if (hit_lo | hit_hi) begin
                  loc_hi_d   = hit_hi;
                  loc_we_d   = wbs_we_i;
                  loc_sel0_d = wbs_sel_i[0];
               end else begin
                  h_we_d  = wbs_we_i;
                  h_sel_d = wbs_sel_i;
                  h_adr_d = wbs_adr_i;
                  h_dat_d = wbs_dat_i;
               end
            end
         end
         S_REQ: begin
            if (wbs_cyc_i) begin
               if (h_ack_i) begin
                  dat_d = h_dat_i;
               end else if (wait_last) begin
                  dat_d  = TIMEOUT_DATA;
                  irq_d  = 1'b1;
                  last_d = h_adr_q;
                  if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
         end
         S_LOCAL: begin
            dat_d = '0;
            if (!loc_we_q)                  dat_d = loc_hi_q ? last_q : 32'(cnt_q);
            else if (!loc_hi_q && loc_sel0_q) cnt_d = '0;
         end
         S_DRAIN: if (drain_done) dat_d = '0;
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wait_q     <= '0;
         cnt_q      <= '0;
         last_q     <= '0;
         dat_q      <= '0;
         irq_q      <= 1'b0;
         h_we_q     <= 1'b0;
         h_sel_q    <= '0;
         h_adr_q    <= '0;
         h_dat_q    <= '0;
         loc_hi_q   <= 1'b0;
         loc_we_q   <= 1'b0;
         loc_sel0_q <= 1'b0;
      end else begin
         wait_q     <= wait_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         dat_q      <= dat_d;
         irq_q      <= irq_d;
         h_we_q     <= h_we_d;
         h_sel_q    <= h_sel_d;
         h_adr_q    <= h_adr_d;
         h_dat_q    <= h_dat_d;
         loc_hi_q   <= loc_hi_d;
         loc_we_q   <= loc_we_d;
         loc_sel0_q <= loc_sel0_d;
      end
   end

endmodule
